// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the Chronos RV32I pipeline.
// Issues in-order word fetches to instruction memory under a credit scheme
// (outstanding requests + buffered words never exceed BUF_DEPTH), keeps the
// PC of each live request in a small queue, pairs returned words with those
// PCs in a response buffer and presents one {pc, instr} per cycle. A redirect
// flushes everything and arms a drop counter that swallows the responses of
// requests that were still in flight.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] buf_count_q, buf_count_d;
    logic [PTR_W-1:0] buf_rd_ptr_q, buf_rd_ptr_d;
    logic [PTR_W-1:0] buf_wr_ptr_q, buf_wr_ptr_d;
    logic [PTR_W-1:0] ifq_rd_ptr_q, ifq_rd_ptr_d;
    logic [PTR_W-1:0] ifq_wr_ptr_q, ifq_wr_ptr_d;

    // Storage: response buffer (pc + word) and in-flight PC queue.
    logic [31:0] buf_pc_q    [BUF_DEPTH];
    logic [31:0] buf_instr_q [BUF_DEPTH];
    logic [31:0] ifq_pc_q    [BUF_DEPTH];

    logic credit_ok;
    logic issue;
    logic resp;
    logic resp_keep;
    logic buf_push;
    logic buf_pop;
    logic buf_empty;
    logic unused_redirect_lsbs;

    // Low address bits of a redirect target are forced to zero.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Request, handshake and output decode.
    always_comb begin
        buf_empty = (buf_count_q == '0);
        credit_ok = ({1'b0, outstanding_q} + {1'b0, buf_count_q}) < (CNT_W + 1)'(BUF_DEPTH);
        imem_req  = rst & ~redirect & credit_ok;
        imem_addr = fetch_pc_q;
        issue     = imem_req & imem_ready;
        // A response with nothing outstanding is a protocol violation: ignore it.
        resp      = imem_rvalid & (outstanding_q != '0);
        // Stale responses and a response landing in a redirect cycle are dropped.
        resp_keep = resp & (drop_cnt_q == '0) & ~redirect;
        buf_push  = resp_keep;
        out_valid = ~buf_empty & ~stall & ~redirect;
        buf_pop   = out_valid;
        out_pc    = buf_empty ? 32'h0 : buf_pc_q[buf_rd_ptr_q];
        out_instr = buf_empty ? 32'h0 : buf_instr_q[buf_rd_ptr_q];
    end

    // Next-state computation for PC, counters and queue pointers.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(resp);
        drop_cnt_d    = drop_cnt_q;
        buf_count_d   = buf_count_q;
        buf_rd_ptr_d  = buf_rd_ptr_q;
        buf_wr_ptr_d  = buf_wr_ptr_q;
        ifq_rd_ptr_d  = ifq_rd_ptr_q;
        ifq_wr_ptr_d  = ifq_wr_ptr_q;
        if (redirect) begin
            // No issue in this cycle, so every request still outstanding
            // after this cycle's response is stale.
            fetch_pc_d   = {redirect_pc[31:2], 2'b00};
            drop_cnt_d   = outstanding_d;
            buf_count_d  = '0;
            buf_rd_ptr_d = '0;
            buf_wr_ptr_d = '0;
            ifq_rd_ptr_d = '0;
            ifq_wr_ptr_d = '0;
        end else begin
            if (issue) begin
                fetch_pc_d   = fetch_pc_q + 32'd4;
                ifq_wr_ptr_d = ifq_wr_ptr_q + PTR_W'(1);
            end
            if (resp && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
            if (resp_keep) begin
                ifq_rd_ptr_d = ifq_rd_ptr_q + PTR_W'(1);
                buf_wr_ptr_d = buf_wr_ptr_q + PTR_W'(1);
            end
            if (buf_pop) begin
                buf_rd_ptr_d = buf_rd_ptr_q + PTR_W'(1);
            end
            buf_count_d = buf_count_q + CNT_W'(buf_push) - CNT_W'(buf_pop);
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            buf_count_q   <= '0;
            buf_rd_ptr_q  <= '0;
            buf_wr_ptr_q  <= '0;
            ifq_rd_ptr_q  <= '0;
            ifq_wr_ptr_q  <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            buf_count_q   <= buf_count_d;
            buf_rd_ptr_q  <= buf_rd_ptr_d;
            buf_wr_ptr_q  <= buf_wr_ptr_d;
            ifq_rd_ptr_q  <= ifq_rd_ptr_d;
            ifq_wr_ptr_q  <= ifq_wr_ptr_d;
        end
    end

    // Per-entry storage; contents are only meaningful while the entry is live.
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
        // Capture the issued PC into its in-flight slot.
        always_ff @(posedge clk) begin
            if (issue && (ifq_wr_ptr_q == PTR_W'(gi))) begin
                ifq_pc_q[gi] <= fetch_pc_q;
            end
        end

        // Pair a kept response with the oldest live in-flight PC.
        always_ff @(posedge clk) begin
            if (buf_push && (buf_wr_ptr_q == PTR_W'(gi))) begin
                buf_pc_q[gi]    <= ifq_pc_q[ifq_rd_ptr_q];
                buf_instr_q[gi] <= imem_rdata;
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the Chronos RV32I pipeline; sits directly upstream of the IF/ID pipeline register.
- Generates sequential PCs and issues in-order requests to instruction memory, which can take several cycles to respond.
- Buffers returned words with their PCs and presents one {pc, instr} per cycle. out_valid drives the downstream register's enable.
- Handles taken-branch/jump redirects, and drops stale in-flight responses after a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH, 2, response buffer entries and maximum requests in flight (power of two, ≥2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- imem_req  output  1  request valid
- imem_addr  output  32  word-aligned fetch address
- imem_ready  input  1  memory accepts request this cycle (issue = imem_req & imem_ready)
- imem_rvalid  input  1  response valid; responses return in order, latency ≥1 cycle
- imem_rdata  input  32  instruction word
- redirect  input  1  flush and restart fetch at redirect_pc
- redirect_pc  input  32  new fetch address; bits [1:0] ignored and forced to 0
- stall  input  1  downstream cannot accept this cycle
- out_valid  output  1  {out_pc, out_instr} valid; doubles as downstream register enable
- out_pc  output  32  PC of presented instruction
- out_instr  output  32  presented instruction

Behaviour:
- Reset (async, rst=0): fetch_pc=RESET_PC; buffer empty; in-flight PC queue empty; outstanding=0; drop_cnt=0; imem_req=0; out_valid=0; out_pc=0; out_instr=0.
- imem_addr always equals fetch_pc.
- imem_req=1 when all of the following hold:
  - rst=1
  - redirect=0
  - outstanding + buf_count < BUF_DEPTH (credit rule: every response is guaranteed a buffer slot)
- On issue:
  - fetch_pc += 4, with 32-bit wrap (32'hFFFF_FFFC → 0).
  - Push the issued PC into the in-flight PC queue.
  - outstanding += 1.
- Response (imem_rvalid=1):
  - outstanding -= 1.
  - If drop_cnt > 0: discard the word, drop_cnt -= 1.
  - Otherwise: pop the in-flight PC and push {pc, imem_rdata} into the buffer.
- Issue and response in the same cycle: outstanding is unchanged.
- Output:
  - out_valid = buffer non-empty & !stall & !redirect.
  - out_pc/out_instr = buffer head when non-empty, else 0.
  - Head is popped when out_valid=1.
  - Push and pop in the same cycle are allowed, including when the buffer is full.
- Latency: request accepted at cycle T, response at T+L → earliest out_valid at T+L+1. No bypass from imem_rdata to the outputs.
- Stall: the buffer holds and the head is stable. Issue continues until credits are exhausted, then imem_req=0.
- Redirect (redirect=1, highest priority):
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - Buffer and in-flight PC queue cleared.
  - drop_cnt <= outstanding after any response arriving this cycle. That response itself is discarded.
  - No issue and out_valid=0 in the redirect cycle.
  - Fetch resumes next cycle.
- Back-to-back redirects: each cycle restarts and recomputes drop_cnt. No request may escape between them.
- While drop_cnt > 0, new requests may issue within credits. Their responses are accepted only after the stale ones are dropped, which in-order return guarantees.
- Reset mid-operation: all state returns to reset values immediately. Any response arriving after reset release with outstanding=0 is a protocol violation; the design ignores it (no push).
- Never overflow or underflow: buffer push when full or pop when empty is an assertion failure in the bench.

Test Plan:
- Reset release, RESET_PC=0, imem_ready=1, latency 1 → requests at 0x0, 0x4, 0x8…; out_valid from cycle 3 with out_pc 0x0, 0x4… and matching instr.
- stall=1 for 5 cycles with latency 1 → at most BUF_DEPTH requests accepted, then imem_req=0. On release, instructions emerge in order with no loss or duplicates.
- redirect to 0x1002 with 2 requests outstanding → imem_addr=0x1000 next cycle. Both stale responses dropped; first out_pc=0x1000.
- redirect asserted in the same cycle as an imem_rvalid → that word is discarded and never appears on out_*.
- fetch_pc=32'hFFFF_FFF8, free-running → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- rst pulled low while 2 requests are outstanding and the buffer is full → outputs immediately 0; after release fetch restarts at RESET_PC.
